// File: rtl/pc_sequencer.sv
// PC sequencer for the single-cycle RISC-V core.
// Owns the program counter, requests instruction fetches from imem, and
// chooses the next PC at retire. The candidates are sequential, jump,
// branch, and trap vector. The block also handles execute stalls, halt/resume,
// and traps raised by misaligned jump or branch targets.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             fetch_req_o,
  input  logic             fetch_ready_i,
  output logic             instr_valid_o,
  input  logic             exec_stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [31:0]      jump_target_i,
  input  logic             trap_req_i,
  input  logic             halt_req_i,
  input  logic             resume_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc_plus4_o,
  output logic [31:0]      mepc_o,
  output logic             trap_taken_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] instret_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      mepc_q, mepc_d;
  logic             trap_taken_q, trap_taken_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic             retire_s;
  logic             redirect_s;
  logic [31:0]      redirect_tgt_s;
  logic             misaligned_s;
  logic             take_trap_s;
  logic [31:0]      pc_plus4_s;

  assign pc_plus4_s = pc_q + 32'd4;

  // State register; a reset in any state drops a pending fetch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: boot, then fetch/execute, with an optional halt after retire.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (fetch_ready_i) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (exec_stall_i) begin
          state_d = ST_EXEC;
        end else if (halt_req_i) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Handshake outputs are decoded directly from the state register.
  always_comb begin
    fetch_req_o   = 1'b0;
    instr_valid_o = 1'b0;
    halted_o      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        fetch_req_o = 1'b0;
      end
      ST_FETCH: begin
        fetch_req_o = 1'b1;
      end
      ST_EXEC: begin
        instr_valid_o = 1'b1;
      end
      ST_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        fetch_req_o = 1'b0;
      end
    endcase
  end

  // Redirect decode: a jump outranks a branch. A target that is not
  // word-aligned becomes a trap instead of a redirect.
  always_comb begin
    retire_s       = (state_q == ST_EXEC) && !exec_stall_i;
    redirect_s     = jump_i || branch_taken_i;
    redirect_tgt_s = 32'h0000_0000;
    if (jump_i) begin
      redirect_tgt_s = jump_target_i;
    end else if (branch_taken_i) begin
      redirect_tgt_s = branch_target_i;
    end else begin
      redirect_tgt_s = pc_plus4_s;
    end
    misaligned_s = redirect_s && (redirect_tgt_s[1:0] != 2'b00);
    take_trap_s  = trap_req_i || misaligned_s;
  end

  // Next-value logic for PC, mepc, the trap pulse and the retired-instruction count.
  always_comb begin
    pc_d         = pc_q;
    mepc_d       = mepc_q;
    trap_taken_d = 1'b0;
    instret_d    = instret_q;
    if (retire_s) begin
      if (take_trap_s) begin
        pc_d         = TRAP_VEC;
        mepc_d       = pc_q;
        trap_taken_d = 1'b1;
      end else if (redirect_s) begin
        pc_d = redirect_tgt_s;
      end else begin
        pc_d = pc_plus4_s;
      end
      // A datapath exception does not retire. A misaligned control transfer
      // still counts as a retired instruction.
      if (trap_req_i) begin
        instret_d = instret_q;
      end else begin
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // Datapath registers, with synchronous reset to the boot values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_PC;
      mepc_q       <= 32'h0000_0000;
      trap_taken_q <= 1'b0;
      instret_q    <= {CNT_W{1'b0}};
    end else begin
      pc_q         <= pc_d;
      mepc_q       <= mepc_d;
      trap_taken_q <= trap_taken_d;
      instret_q    <= instret_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_plus4_o   = pc_plus4_s;
  assign mepc_o       = mepc_q;
  assign trap_taken_o = trap_taken_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer. Each row gives the inputs
// for one clock edge and the outputs expected just after that edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, fetch_ready, exec_stall, branch_taken, jump, trap_req, halt_req, resume;
  logic [31:0] branch_target, jump_target;
  logic        fetch_req, instr_valid, trap_taken, halted;
  logic [31:0] pc, pc_plus4, mepc, instret;

  int errors = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .fetch_req_o(fetch_req), .fetch_ready_i(fetch_ready),
    .instr_valid_o(instr_valid), .exec_stall_i(exec_stall),
    .branch_taken_i(branch_taken), .branch_target_i(branch_target),
    .jump_i(jump), .jump_target_i(jump_target),
    .trap_req_i(trap_req), .halt_req_i(halt_req), .resume_i(resume),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .mepc_o(mepc),
    .trap_taken_o(trap_taken), .halted_o(halted), .instret_o(instret)
  );

  always #5 clk = ~clk;

  // ctl = {rst, fetch_ready, exec_stall, branch_taken, jump, trap_req, halt_req, resume}
  // flg = {fetch_req, instr_valid, halted, trap_taken}
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] btgt;
    logic [31:0] jtgt;
    logic [3:0]  flg;
    logic [31:0] epc;
    logic [31:0] emepc;
    logic [31:0] eir;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic [7:0] c, input logic [31:0] bt, input logic [31:0] jt,
                     input logic [3:0] f, input logic [31:0] p, input logic [31:0] m,
                     input logic [31:0] ir);
    vec_t v;
    v.ctl = c; v.btgt = bt; v.jtgt = jt; v.flg = f; v.epc = p; v.emepc = m; v.eir = ir;
    tv.push_back(v);
  endtask

  task automatic apply_and_check(input int idx, input vec_t v);
    logic [135:0] act, exp_v;
    logic [31:0]  exp_p4;
    {rst, fetch_ready, exec_stall, branch_taken, jump, trap_req, halt_req, resume} = v.ctl;
    branch_target = v.btgt;
    jump_target   = v.jtgt;
    @(posedge clk);
    #1;
    exp_p4 = v.epc + 32'd4;
    act   = {fetch_req, instr_valid, halted, trap_taken, pc, pc_plus4, mepc, instret};
    exp_v = {v.flg, v.epc, exp_p4, v.emepc, v.eir};
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL step%0d: got fetch/valid/halt/trap=%b pc=%h pc4=%h mepc=%h instret=%0d ; want %b pc=%h pc4=%h mepc=%h instret=%0d",
               idx, act[135:132], pc, pc_plus4, mepc, instret,
               v.flg, v.epc, exp_p4, v.emepc, v.eir);
    end
  endtask

  initial begin
    {rst, fetch_ready, exec_stall, branch_taken, jump, trap_req, halt_req, resume} = 8'b1000_0000;
    branch_target = 32'h0;
    jump_target   = 32'h0;

    // Reset, then sequential fetch/execute: pc 0,4,8,C,10 and instret reaches 5.
    add(8'b1100_0000, 32'h0, 32'h0, 4'b0000, 32'h00, 32'h0, 32'd0);
    add(8'b1100_0000, 32'h0, 32'h0, 4'b0000, 32'h00, 32'h0, 32'd0);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h00, 32'h0, 32'd0);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h00, 32'h0, 32'd0);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h04, 32'h0, 32'd1);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h04, 32'h0, 32'd1);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h08, 32'h0, 32'd2);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h08, 32'h0, 32'd2);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h0C, 32'h0, 32'd3);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h0C, 32'h0, 32'd3);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h10, 32'h0, 32'd4);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h10, 32'h0, 32'd4);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b1000, 32'h14, 32'h0, 32'd5);
    // fetch_ready low for 3 cycles (trap_req in FETCH is ignored), then 2 stall cycles.
    add(8'b0000_0000, 32'h0, 32'h0,  4'b1000, 32'h14, 32'h0, 32'd5);
    add(8'b0000_0100, 32'h0, 32'h0,  4'b1000, 32'h14, 32'h0, 32'd5);
    add(8'b0000_0000, 32'h0, 32'h0,  4'b1000, 32'h14, 32'h0, 32'd5);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h14, 32'h0, 32'd5);
    add(8'b0110_1000, 32'h0, 32'h40, 4'b0100, 32'h14, 32'h0, 32'd5);
    add(8'b0110_0000, 32'h0, 32'h0,  4'b0100, 32'h14, 32'h0, 32'd5);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b1000, 32'h18, 32'h0, 32'd6);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h18, 32'h0, 32'd6);
    // Jump to 0x8; jump beats branch (-> 0x40); misaligned branch to 0x22 traps.
    add(8'b0100_1000, 32'h0,  32'h08, 4'b1000, 32'h08,  32'h00, 32'd7);
    add(8'b0100_0000, 32'h0,  32'h0,  4'b0100, 32'h08,  32'h00, 32'd7);
    add(8'b0101_1000, 32'h80, 32'h40, 4'b1000, 32'h40,  32'h00, 32'd8);
    add(8'b0100_0000, 32'h0,  32'h0,  4'b0100, 32'h40,  32'h00, 32'd8);
    add(8'b0101_0000, 32'h22, 32'h0,  4'b1001, 32'h100, 32'h40, 32'd9);
    add(8'b0100_0000, 32'h0,  32'h0,  4'b0100, 32'h100, 32'h40, 32'd9);
    // trap_req at pc 0x10 outranks a jump and is not counted.
    add(8'b0100_1000, 32'h0, 32'h10, 4'b1000, 32'h10,  32'h40, 32'd10);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h10,  32'h40, 32'd10);
    add(8'b0100_1100, 32'h0, 32'h40, 4'b1001, 32'h100, 32'h10, 32'd10);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h100, 32'h10, 32'd10);
    // Resume outside HALT is ignored; halt_req at pc 0x4 retires, then halts at pc 0x8.
    add(8'b0100_1001, 32'h0, 32'h04, 4'b1000, 32'h04, 32'h10, 32'd11);
    add(8'b0100_0001, 32'h0, 32'h0,  4'b0100, 32'h04, 32'h10, 32'd11);
    add(8'b0100_0010, 32'h0, 32'h0,  4'b0010, 32'h08, 32'h10, 32'd12);
    // Ten halted cycles with no fetch; redirect and halt inputs are ignored.
    for (int i = 0; i < 10; i++)
      add(8'b0100_1010, 32'h0, 32'h200, 4'b0010, 32'h08, 32'h10, 32'd12);
    // Resume fetches 0x8; trap together with halt: redirect first, then HALT.
    add(8'b0100_0001, 32'h0, 32'h0, 4'b1000, 32'h08,  32'h10, 32'd12);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h08,  32'h10, 32'd12);
    add(8'b0100_0110, 32'h0, 32'h0, 4'b0011, 32'h100, 32'h08, 32'd12);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0010, 32'h100, 32'h08, 32'd12);
    add(8'b0100_0001, 32'h0, 32'h0, 4'b1000, 32'h100, 32'h08, 32'd12);
    add(8'b0100_0000, 32'h0, 32'h0, 4'b0100, 32'h100, 32'h08, 32'd12);
    // Reset in FETCH at pc 0x30 restores every reset value.
    add(8'b0100_1000, 32'h0, 32'h30, 4'b1000, 32'h30, 32'h08, 32'd13);
    add(8'b1100_0000, 32'h0, 32'h0,  4'b0000, 32'h00, 32'h00, 32'd0);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b1000, 32'h00, 32'h00, 32'd0);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h00, 32'h00, 32'd0);
    // Sequential step from 0xFFFF_FFFC wraps to 0.
    add(8'b0100_1000, 32'h0, 32'hFFFF_FFFC, 4'b1000, 32'hFFFF_FFFC, 32'h0, 32'd1);
    add(8'b0100_0000, 32'h0, 32'h0,         4'b0100, 32'hFFFF_FFFC, 32'h0, 32'd1);
    add(8'b0100_0000, 32'h0, 32'h0,         4'b1000, 32'h0000_0000, 32'h0, 32'd2);
    // A misaligned jump target traps. The jump itself still counts as retired.
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h000, 32'h0, 32'd2);
    add(8'b0100_1000, 32'h0, 32'h02, 4'b1001, 32'h100, 32'h0, 32'd3);
    add(8'b0100_0000, 32'h0, 32'h0,  4'b0100, 32'h100, 32'h0, 32'd3);

    foreach (tv[i]) apply_and_check(i, tv[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
